// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DBIT data bits LSB first, optional parity, stop period.
// Bit timing comes from a 16x-baud s_tick enable. tx, tx_busy and tx_done_tick are all registered.
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] BIT_LAST = 5'd15;
    localparam logic [4:0] SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST   = 3'(DBIT - 1);

    state_t          state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            p_reg, p_next;
    logic            tx_reg, tx_next;
    logic            busy_reg;
    logic            done_reg, done_next;

    function automatic logic parity_of(input logic [DBIT-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= 1'b0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            p_reg     <= p_next;
            tx_reg    <= tx_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        p_next     = p_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // A tick coinciding with acceptance is deliberately not counted.
                if (tx_start) begin
                    b_next     = din;
                    p_next     = parity_of(din);
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST)
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            n_next = n_reg + 3'd1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == SB_LAST) begin
                        s_next     = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level follows the upcoming state so tx changes on the same edge as the state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
            PARITY:  tx_next = p_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign tx           = tx_reg;
    assign tx_busy      = busy_reg;
    assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames pushed to an expected queue, a line monitor decodes tx and checks.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       start0, start1, start2;
    logic [7:0] din;
    logic       done0, busy0, tx0;
    logic       done1, busy1, tx1;
    logic       done2, busy2, tx2;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   sel = 0;
    int   bit_clks = 16;
    bit   tick_fast = 1'b1;
    logic [1:0] mcnt = 2'd0;
    logic mon_tx, busy_s, done_s;
    logic wave [0:255];
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    // Mod-4 baud generator, or a tick every clock when tick_fast is set.
    always @(posedge clk) mcnt <= mcnt + 2'd1;
    assign s_tick = tick_fast ? 1'b1 : (mcnt == 2'd3);

    uart_tx dut0 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start0), .din(din),
                  .tx_done_tick(done0), .tx_busy(busy0), .tx(tx0));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (.clk(clk), .reset(reset), .s_tick(s_tick),
                  .tx_start(start1), .din(din), .tx_done_tick(done1), .tx_busy(busy1), .tx(tx1));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clk(clk), .reset(reset), .s_tick(s_tick),
                  .tx_start(start2), .din(din), .tx_done_tick(done2), .tx_busy(busy2), .tx(tx2));

    always_comb begin
        case (sel)
            1:       begin mon_tx = tx1; busy_s = busy1; done_s = done1; end
            2:       begin mon_tx = tx2; busy_s = busy2; done_s = done2; end
            default: begin mon_tx = tx0; busy_s = busy0; done_s = done0; end
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Frame bits by position: 0 = start, 1..8 = data LSB first, then parity (if any), then stop.
    task automatic push_frame(input logic [7:0] d, input bit pen, input logic pb);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i+1] = d[i];
        if (pen) begin
            v[9]  = pb;
            v[10] = 1'b1;
        end else begin
            v[9] = 1'b1;
        end
        exp_q.push_back(v);
    endtask

    // Called one sample after the accepting edge; returns on the sample where done is high.
    task automatic run_frame(input int budget, output int busy_n, output int done_n);
        bit got;
        got = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < budget && !got; i++) begin
            if (i < 256) wave[i] = mon_tx;
            if (busy_s) busy_n++;
            if (done_s) begin
                done_n++;
                got = 1'b1;
            end else begin
                cyc();
            end
        end
        if (!got) check("frame_timeout", 0, 1);
    endtask

    // Line monitor: detects the start edge and samples each bit at mid-period.
    initial begin : monitor
        bit          act;
        logic        prev;
        int          cnt, k, nb;
        logic [11:0] rx;
        logic [11:0] e;
        act = 1'b0;
        prev = 1'b1;
        cnt = 0;
        k = 0;
        nb = 10;
        rx = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                act = 1'b0;
            end else if (!act) begin
                if (prev && !mon_tx) begin
                    act = 1'b1;
                    cnt = 0;
                    k = 0;
                    rx = '0;
                    nb = (sel == 0) ? 10 : 11;
                end
            end else begin
                cnt++;
            end
            if (act && cnt == k * bit_clks + bit_clks / 2) begin
                rx[k] = mon_tx;
                k++;
                if (k == nb) begin
                    act = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", rx, 12'h000);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", rx, e);
                    end
                end
            end
            prev = mon_tx;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   bn, dn, errs, extra;
        logic seq [0:9];
        logic [7:0] a5;
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        din = 8'h00;

        // Reset with a pending request: nothing may start.
        start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("reset_outputs", {tx0, busy0, done0}, 3'b100);
        end
        reset = 1'b0;
        start0 = 1'b0;
        repeat (3) cyc();
        check("post_reset_idle", {tx0, busy0}, 2'b10);

        // Basic frame 0xA5, tick every clock.
        a5 = 8'hA5;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = a5[i];
        seq[9] = 1'b1;
        din = 8'hA5;
        push_frame(8'hA5, 1'b0, 1'b0);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        run_frame(400, bn, dn);
        check("t2_busy_cycles", bn, 160);
        check("t2_done_count", dn, 1);
        errs = 0;
        for (int i = 0; i < 160; i++) if (wave[i] !== seq[i / 16]) errs++;
        check("t2_wave_errors", errs, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done0 || !tx0) extra++;
        end
        check("t2_idle_after", extra, 0);

        // Mod-4 tick generator, 0x3C.
        tick_fast = 1'b0;
        bit_clks = 64;
        din = 8'h3C;
        push_frame(8'h3C, 1'b0, 1'b0);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        run_frame(2000, bn, dn);
        check("t3_done_count", dn, 1);
        check("t3_busy_min", (bn >= 637) ? 1 : 0, 1);
        repeat (10) cyc();

        // Parity, even then odd, din = 0x07.
        tick_fast = 1'b1;
        bit_clks = 16;
        sel = 1;
        din = 8'h07;
        push_frame(8'h07, 1'b1, 1'b1);
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        run_frame(400, bn, dn);
        check("t4_even_busy", bn, 176);
        repeat (10) cyc();
        sel = 2;
        push_frame(8'h07, 1'b1, 1'b0);
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        run_frame(400, bn, dn);
        check("t4_odd_busy", bn, 176);
        repeat (10) cyc();
        sel = 0;

        // Mid-frame request is ignored.
        din = 8'h81;
        push_frame(8'h81, 1'b0, 1'b0);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        repeat (40) cyc();
        din = 8'hFF;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        run_frame(400, bn, dn);
        check("t5_ignored_busy", bn, 119);
        repeat (20) cyc();
        check("t5_no_restart", busy0, 0);

        // Start held across done: second frame follows the stop period directly.
        din = 8'h55;
        push_frame(8'h55, 1'b0, 1'b0);
        push_frame(8'h0F, 1'b0, 1'b0);
        start0 = 1'b1;
        cyc();
        din = 8'h0F;
        run_frame(400, bn, dn);
        check("t5_first_busy", bn, 160);
        cyc();
        check("t5_b2b_start", {busy0, tx0}, 2'b10);
        start0 = 1'b0;
        run_frame(400, bn, dn);
        check("t5_second_done", dn, 1);
        repeat (10) cyc();

        // Reset during data bit 3 of 0x00.
        din = 8'h00;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        repeat (70) cyc();
        check("t6_mid_data_low", {busy0, tx0}, 2'b10);
        reset = 1'b1;
        cyc();
        check("t6_abort_outputs", {tx0, busy0, done0}, 3'b100);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (done0) extra++;
        end
        check("t6_no_done", extra, 0);
        din = 8'hC3;
        push_frame(8'hC3, 1'b0, 1'b0);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        run_frame(400, bn, dn);
        check("t6_clean_busy", bn, 160);

        repeat (30) cyc();
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
